// File: rtl/fft8_in_buf.sv
// Serial-to-parallel input buffer for an 8-point FFT: collects 8 complex samples
// into a fill bank and publishes them as one registered frame with a strobe.
module fft8_in_buf #(
  parameter int DW = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic signed [DW-1:0] in_real,
  input  logic signed [DW-1:0] in_imag,
  output logic signed [DW-1:0] x0_real,
  output logic signed [DW-1:0] x1_real,
  output logic signed [DW-1:0] x2_real,
  output logic signed [DW-1:0] x3_real,
  output logic signed [DW-1:0] x4_real,
  output logic signed [DW-1:0] x5_real,
  output logic signed [DW-1:0] x6_real,
  output logic signed [DW-1:0] x7_real,
  output logic signed [DW-1:0] x0_imag,
  output logic signed [DW-1:0] x1_imag,
  output logic signed [DW-1:0] x2_imag,
  output logic signed [DW-1:0] x3_imag,
  output logic signed [DW-1:0] x4_imag,
  output logic signed [DW-1:0] x5_imag,
  output logic signed [DW-1:0] x6_imag,
  output logic signed [DW-1:0] x7_imag,
  output logic                 en,
  output logic                 frame_drop,
  output logic [7:0]           drop_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic                complete_q, complete_d;
  logic                en_q, en_d;
  logic                drop_q, drop_d;
  logic [7:0]          cnt_q, cnt_d;
  logic signed [DW-1:0] fill_re_q [8];
  logic signed [DW-1:0] fill_re_d [8];
  logic signed [DW-1:0] fill_im_q [8];
  logic signed [DW-1:0] fill_im_d [8];
  logic signed [DW-1:0] out_re_q [8];
  logic signed [DW-1:0] out_re_d [8];
  logic signed [DW-1:0] out_im_q [8];
  logic signed [DW-1:0] out_im_d [8];

  // The output bank copies the fill bank one edge after the 8th sample lands; a
  // sof accepted on that same edge overwrites only fill slot 0, so the copy
  // still sees the completed frame.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    complete_d = 1'b0;
    en_d       = complete_q;
    drop_d     = 1'b0;
    cnt_d      = cnt_q;
    fill_re_d  = fill_re_q;
    fill_im_d  = fill_im_q;
    out_re_d   = out_re_q;
    out_im_d   = out_im_q;

    if (complete_q) begin
      out_re_d = fill_re_q;
      out_im_d = fill_im_q;
    end

    if (in_valid) begin
      case (state_q)
        IDLE: begin
          if (in_sof) begin
            fill_re_d[0] = in_real;
            fill_im_d[0] = in_imag;
            idx_d        = 3'd1;
            state_d      = FILL;
          end
        end
        FILL: begin
          if (in_sof) begin
            drop_d       = 1'b1;
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            fill_re_d[0] = in_real;
            fill_im_d[0] = in_imag;
            idx_d        = 3'd1;
          end else begin
            fill_re_d[idx_q] = in_real;
            fill_im_d[idx_q] = in_imag;
            if (idx_q == 3'd7) begin
              idx_d      = 3'd0;
              state_d    = IDLE;
              complete_d = 1'b1;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      complete_q <= 1'b0;
      en_q       <= 1'b0;
      drop_q     <= 1'b0;
      cnt_q      <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        fill_re_q[i] <= '0;
        fill_im_q[i] <= '0;
        out_re_q[i]  <= '0;
        out_im_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      complete_q <= complete_d;
      en_q       <= en_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      fill_re_q  <= fill_re_d;
      fill_im_q  <= fill_im_d;
      out_re_q   <= out_re_d;
      out_im_q   <= out_im_d;
    end
  end

  assign en         = en_q;
  assign frame_drop = drop_q;
  assign drop_cnt   = cnt_q;

  assign x0_real = out_re_q[0];
  assign x1_real = out_re_q[1];
  assign x2_real = out_re_q[2];
  assign x3_real = out_re_q[3];
  assign x4_real = out_re_q[4];
  assign x5_real = out_re_q[5];
  assign x6_real = out_re_q[6];
  assign x7_real = out_re_q[7];
  assign x0_imag = out_im_q[0];
  assign x1_imag = out_im_q[1];
  assign x2_imag = out_im_q[2];
  assign x3_imag = out_im_q[3];
  assign x4_imag = out_im_q[4];
  assign x5_imag = out_im_q[5];
  assign x6_imag = out_im_q[6];
  assign x7_imag = out_im_q[7];

endmodule

// File: tb/tb_fft8_in_buf.sv
// Directed self-checking bench for fft8_in_buf: reset, back-to-back, gaps,
// early sof, missing sof, reset mid-frame and drop counter saturation.
module tb_fft8_in_buf;

  localparam int DW = 24;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_sof;
  logic signed [DW-1:0] in_real;
  logic signed [DW-1:0] in_imag;
  logic signed [DW-1:0] xr [8];
  logic signed [DW-1:0] xi [8];
  logic                 en;
  logic                 frame_drop;
  logic [7:0]           drop_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int en_count    = 0;
  int drop_pulses = 0;
  int en_base;
  int drop_base;

  fft8_in_buf #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
    .in_real(in_real), .in_imag(in_imag),
    .x0_real(xr[0]), .x1_real(xr[1]), .x2_real(xr[2]), .x3_real(xr[3]),
    .x4_real(xr[4]), .x5_real(xr[5]), .x6_real(xr[6]), .x7_real(xr[7]),
    .x0_imag(xi[0]), .x1_imag(xi[1]), .x2_imag(xi[2]), .x3_imag(xi[3]),
    .x4_imag(xi[4]), .x5_imag(xi[5]), .x6_imag(xi[6]), .x7_imag(xi[7]),
    .en(en), .frame_drop(frame_drop), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobes are counted mid-cycle, well away from the rising edge.
  always @(negedge clk) begin
    if (en) en_count++;
    if (frame_drop) drop_pulses++;
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive on the falling edge, return 1 time unit after the rising edge.
  task automatic cycle(input logic r, input logic v, input logic s,
                       input int re, input int im);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    in_sof   = s;
    in_real  = re[DW-1:0];
    in_imag  = im[DW-1:0];
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic s, input int re, input int im);
    cycle(1'b0, 1'b1, s, re, im);
  endtask

  task automatic gap();
    cycle(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic check_frame(input string tag, input int re_base, input int re_step,
                             input int im_base, input int im_step);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_re%0d", tag, i), xr[i], re_base + re_step * i);
      check($sformatf("%s_im%0d", tag, i), xi[i], im_base + im_step * i);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_real = '0; in_imag = '0;

    // Reset, with valid sof presented to show reset priority.
    cycle(1'b1, 1'b1, 1'b1, 5, 5);
    cycle(1'b1, 1'b0, 1'b0, 0, 0);
    check("rst_en", en, 0);
    check("rst_drop", frame_drop, 0);
    check("rst_cnt", drop_cnt, 0);
    check_frame("rst", 0, 0, 0, 0);

    // Missing sof from IDLE: everything ignored.
    en_base = en_count; drop_base = drop_pulses;
    for (int k = 0; k < 5; k++) sample(1'b0, 20 + k, 30 + k);
    gap(); gap();
    check("nosof_en", en_count - en_base, 0);
    check("nosof_drop", drop_pulses - drop_base, 0);
    check_frame("nosof", 0, 0, 0, 0);

    // Back-to-back: two frames, sof on samples 0 and 8.
    en_base = en_count;
    for (int k = 0; k < 16; k++) begin
      sample((k == 0) || (k == 8), k, -k);
      if (k == 7) check("b2b_en_early", en, 0);
      if (k == 8) begin
        check("b2b_en1", en, 1);
        check_frame("b2b_f1", 0, 1, 0, -1);
      end
      if (k == 9) begin
        check("b2b_en1_off", en, 0);
        check_frame("b2b_hold", 0, 1, 0, -1);
      end
    end
    gap();
    check("b2b_en2", en, 1);
    check_frame("b2b_f2", 8, 1, -8, -1);
    gap();
    check("b2b_en_count", en_count - en_base, 2);
    check("b2b_cnt", drop_cnt, 0);

    // Gaps between every sample.
    en_base = en_count;
    for (int k = 0; k < 8; k++) begin
      sample(k == 0, 100 + k, 3 * k);
      if (k == 7) begin
        check("gap_en_early", en, 0);
        check_frame("gap_hold", 8, 1, -8, -1);
      end else begin
        gap();
      end
    end
    gap();
    check("gap_en", en, 1);
    check_frame("gap", 100, 1, 0, 3);
    gap();
    check("gap_en_count", en_count - en_base, 1);

    // Early sof abandons a 3-sample partial frame.
    en_base = en_count; drop_base = drop_pulses;
    sample(1'b1, 1, 0); sample(1'b0, 2, 0); sample(1'b0, 3, 0);
    sample(1'b1, 50, -50);
    check("early_drop", frame_drop, 1);
    check("early_cnt", drop_cnt, 1);
    for (int k = 1; k < 8; k++) sample(1'b0, 50 + k, -50 - k);
    check("early_drop_off", frame_drop, 0);
    gap();
    check("early_en", en, 1);
    check_frame("early", 50, 1, -50, -1);
    gap();
    check("early_en_count", en_count - en_base, 1);
    check("early_drop_count", drop_pulses - drop_base, 1);

    // Reset mid-frame, then a negative-valued frame.
    en_base = en_count; drop_base = drop_pulses;
    sample(1'b1, 9, 9);
    for (int k = 0; k < 4; k++) sample(1'b0, 9, 9);
    cycle(1'b1, 1'b0, 1'b0, 0, 0);
    check("mid_rst_cnt", drop_cnt, 0);
    check_frame("mid_rst", 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) sample(k == 0, -8 + k, k);
    gap();
    check("neg_en", en, 1);
    check_frame("neg", -8, 1, 0, 1);
    check("neg_sign_bit", xr[0][DW-1], 1);
    gap();
    check("neg_en_count", en_count - en_base, 1);
    check("neg_drop_count", drop_pulses - drop_base, 0);
    check("neg_cnt", drop_cnt, 0);

    // Saturation: 301 sofs, each followed by one sample, give 300 drops.
    drop_base = drop_pulses;
    for (int i = 0; i <= 300; i++) begin
      sample(1'b1, i, 0);
      if (i == 254) check("sat_254", drop_cnt, 254);
      if (i == 255) check("sat_255", drop_cnt, 255);
      sample(1'b0, i, 1);
    end
    gap();
    check("sat_hold", drop_cnt, 255);
    check("sat_pulses", drop_pulses - drop_base, 300);
    check("sat_no_en", en, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fft8_in_buf.md
FFT8_IN_BUF -- requirements
Module: fft8_in_buf

Interface
REQ-001 SHALL have parameter: DW, 24, sample component width (signed two's complement).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  input sample qualifier.
REQ-005 SHALL have port: in_sof  input  1  start-of-frame marker, meaningful only with in_valid=1.
REQ-006 SHALL have port: in_real  input  DW  sample real part, signed.
REQ-007 SHALL have port: in_imag  input  DW  sample imaginary part, signed.
REQ-008 SHALL have ports: x0_real..x7_real and x0_imag..x7_imag  output  DW each  parallel frame in natural time order, registered.
REQ-009 SHALL have port: en  output  1  one-cycle frame strobe to downstream fft8.
REQ-010 SHALL have port: frame_drop  output  1  one-cycle pulse when a partial frame is discarded.
REQ-011 SHALL have port: drop_cnt  output  8  saturating count of discarded frames.

Function
REQ-012 SHALL operate as a serial-to-parallel collector: 8 accepted samples form one frame, sample n lands in xn_real/xn_imag.
REQ-013 SHALL accept a sample only in cycles with in_valid=1; in_valid=0 cycles (gaps) SHALL not change the fill index.
REQ-014 SHALL implement two states: IDLE (no frame in progress) and FILL (index 1..7 pending).
REQ-015 IDLE: in_valid=1 with in_sof=1 -> store at index 0, index:=1, go FILL; in_valid=1 with in_sof=0 -> sample discarded, stay IDLE, no drop pulse.
REQ-016 FILL: in_valid=1, in_sof=0 -> store at current index, index+1; on storing index 7 -> frame complete, go IDLE.
REQ-017 FILL: in_valid=1, in_sof=1 -> partial frame discarded, frame_drop=1 next cycle, drop_cnt+1 (saturate at 255), new sample stored at index 0, index:=1, stay FILL.
REQ-018 SHALL use ping-pong storage: samples written into the fill bank; output bank registers x0..x7 change only on frame completion.
REQ-019 On completion, in the cycle after the 8th sample is accepted, all 16 outputs SHALL present the completed frame and en SHALL be 1 for exactly that cycle.
REQ-020 Latency: 8th sample accepted at edge N -> outputs updated and en=1 after edge N+1 (one register stage after capture).
REQ-021 Outputs SHALL hold the last completed frame unchanged until the next completion; a back-to-back stream (in_valid=1 every cycle) SHALL yield en once every 8 cycles with no lost samples.
REQ-022 A new frame MAY begin (sof) in the same cycle en is asserted for the previous frame; both SHALL be handled without loss.
REQ-023 A sof on the sample that would be index 0 after a completed frame is normal and SHALL not count as a drop.
REQ-024 Data SHALL pass bit-exact; no scaling, rounding or reordering (bit-reversal is done inside fft8).
REQ-025 Partially filled bank contents SHALL never appear on outputs.

Reset
REQ-026 With rst=1 at a clock edge: state:=IDLE, index:=0, en:=0, frame_drop:=0, drop_cnt:=0, all x*_real/x*_imag:=0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame without a frame_drop pulse or drop_cnt increment; no en issued.
REQ-028 rst SHALL take priority over all inputs in the same cycle.

Verification
REQ-029 Back-to-back: 16 valid samples, sof on 1st and 9th, real=k, imag=-k (k=0..15) -> en at cycles 9 and 17; first frame x0..x7_real=0..7, imag=0..-7; second 8..15; drop_cnt=0.
REQ-030 Gaps: 8 samples real=100..107 with in_valid=0 inserted between each -> single en one cycle after 8th sample; outputs 100..107; outputs unchanged before that.
REQ-031 Early sof: sof, 3 samples (real 1,2,3 including sof), then sof + 8 samples real 50..57 -> frame_drop pulse once, drop_cnt=1, en once with x0..x7_real=50..57.
REQ-032 Missing sof: 5 valid samples with in_sof=0 from IDLE -> no en, no frame_drop, outputs stay 0.
REQ-033 Reset mid-frame: sof + 4 samples, rst=1 one cycle, then full frame real=-8..-1 -> all outputs 0 after reset, drop_cnt=0, en once with -8..-1 (sign-extended to DW).
REQ-034 Saturation: 300 partial frames each interrupted by sof -> drop_cnt=255 and holds; frame_drop pulses each time.
